// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider and its tick consumers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_divider_pkg;

  // Default width of the period, duty and count registers.
  localparam int DEFAULT_WIDTH = 16;

  // PWM run state. IDLE holds the output low until a nonzero period commits.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_config_shadow.sv
// Double-buffered PWM period/duty: pending registers capture loads, active registers change only on commit.
// Latency: load captured at the edge it is sampled; committed values appear one edge after i_COMMIT.
// Backpressure: none; a load before commit overwrites the pending values (last load wins).
//
// Ports:
//   i_CLK, i_RESET_N  clock and async active-low reset
//   i_LOAD            one-cycle capture request for i_PERIOD / i_DUTY
//   i_COMMIT          move a configuration into the active registers this cycle
//   i_BYPASS_EN       a load coincident with a commit is committed directly (used at wrap)
//   o_PENDING         a captured configuration is waiting
//   o_ACT_PERIOD      active period (registered)
//   o_NXT_PERIOD/DUTY next-state active values, so the owner can register outputs from them
module pwm_config_shadow
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_PERIOD,
  input  logic [WIDTH-1:0] i_DUTY,
  input  logic             i_COMMIT,
  input  logic             i_BYPASS_EN,
  output logic             o_PENDING,
  output logic [WIDTH-1:0] o_ACT_PERIOD,
  output logic [WIDTH-1:0] o_NXT_PERIOD,
  output logic [WIDTH-1:0] o_NXT_DUTY
);

  logic [WIDTH-1:0] pend_per_q, pend_per_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] act_per_q, act_per_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic             bypass;

  // At a wrap the incoming load is newer than anything pending, so it wins
  // and never touches the pending registers. In IDLE the commit uses the
  // older pending values and the new load queues behind it.
  assign bypass = i_COMMIT & i_BYPASS_EN & i_LOAD;

  always_comb begin
    act_per_d   = act_per_q;
    act_duty_d  = act_duty_q;
    pend_per_d  = pend_per_q;
    pend_duty_d = pend_duty_q;
    pend_vld_d  = pend_vld_q;

    if (i_COMMIT) begin
      if (bypass) begin
        act_per_d  = i_PERIOD;
        act_duty_d = i_DUTY;
      end else begin
        act_per_d  = pend_per_q;
        act_duty_d = pend_duty_q;
      end
    end

    if (i_LOAD && !bypass) begin
      pend_per_d  = i_PERIOD;
      pend_duty_d = i_DUTY;
    end

    if (bypass) begin
      pend_vld_d = 1'b0;
    end else if (i_LOAD) begin
      pend_vld_d = 1'b1;
    end else if (i_COMMIT) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      pend_per_q  <= '0;
      pend_duty_q <= '0;
      pend_vld_q  <= 1'b0;
      act_per_q   <= '0;
      act_duty_q  <= '0;
    end else begin
      pend_per_q  <= pend_per_d;
      pend_duty_q <= pend_duty_d;
      pend_vld_q  <= pend_vld_d;
      act_per_q   <= act_per_d;
      act_duty_q  <= act_duty_d;
    end
  end

  assign o_PENDING    = pend_vld_q;
  assign o_ACT_PERIOD = act_per_q;
  assign o_NXT_PERIOD = act_per_d;
  assign o_NXT_DUTY   = act_duty_d;

endmodule

// File: rtl/tick_pwm_generator.sv
// Tick-driven PWM: counts divider strobes over a programmable period, output high while count < duty.
// Latency: one cycle from a sampled i_TICK to o_COUNT/o_PWM; all outputs registered.
// Backpressure: none; i_ENABLE low freezes count and PWM, config loads are still captured.
//
// Ports:
//   i_CLK, i_RESET_N  clock (shared with the divider) and async active-low reset
//   i_ENABLE          global run enable
//   i_TICK            one-cycle divider strobe
//   i_LOAD            capture i_PERIOD / i_DUTY (period 0 = stop)
//   o_PWM             registered PWM waveform
//   o_PERIOD_DONE     one-cycle pulse coincident with the count returning to 0
//   o_LOAD_PENDING    a captured configuration is waiting to commit
//   o_COUNT           tick position within the current period
module tick_pwm_generator
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_ENABLE,
  input  logic             i_TICK,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_PERIOD,
  input  logic [WIDTH-1:0] i_DUTY,
  output logic             o_PWM,
  output logic             o_PERIOD_DONE,
  output logic             o_LOAD_PENDING,
  output logic [WIDTH-1:0] o_COUNT
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;

  logic             running;
  logic             adv;
  logic             wrap;
  logic             commit;
  logic             pending;
  logic [WIDTH-1:0] act_period;
  logic [WIDTH-1:0] nxt_period;
  logic [WIDTH-1:0] nxt_duty;

  assign running = (state_q == ST_RUN);
  assign adv     = i_ENABLE & i_TICK & running;
  // act_period is nonzero whenever running, so the decrement cannot underflow
  // in any cycle where wrap can be true.
  assign wrap    = adv & (count_q == (act_period - WIDTH'(1)));
  // IDLE commits any pending config immediately (even with i_ENABLE low);
  // RUN commits only at a wrap, taking a same-cycle load directly.
  assign commit  = (~running & pending) | (wrap & (pending | i_LOAD));

  pwm_config_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .i_CLK       (i_CLK),
    .i_RESET_N   (i_RESET_N),
    .i_LOAD      (i_LOAD),
    .i_PERIOD    (i_PERIOD),
    .i_DUTY      (i_DUTY),
    .i_COMMIT    (commit),
    .i_BYPASS_EN (running),
    .o_PENDING   (pending),
    .o_ACT_PERIOD(act_period),
    .o_NXT_PERIOD(nxt_period),
    .o_NXT_DUTY  (nxt_duty)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (commit) begin
      count_d = '0;
      state_d = (nxt_period != '0) ? ST_RUN : ST_IDLE;
    end else if (wrap) begin
      count_d = '0;
    end else if (adv) begin
      count_d = count_q + WIDTH'(1);
    end
    done_d = wrap;
    // Built from next-state values so o_PWM lines up with o_COUNT; duty >= period
    // keeps this true at count 0 as well, so 100% duty has no wrap glitch.
    pwm_d  = (state_d == ST_RUN) & (count_d < nxt_duty);
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pwm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pwm_q   <= pwm_d;
      done_q  <= done_d;
    end
  end

  assign o_PWM          = pwm_q;
  assign o_PERIOD_DONE  = done_q;
  assign o_LOAD_PENDING = pending;
  assign o_COUNT        = count_q;

endmodule

// File: doc/tick_pwm_generator.md
# tick_pwm_generator

Downstream consumer of the dynamic clock divider's single-cycle enable strobe. It counts divider ticks over a programmable period and drives a PWM output whose high time is a programmable duty count. Period and duty updates are double-buffered and commit only at a period boundary, so the waveform is glitch-free. It sits between `dynamic_clock_divider.o_ENABLE_OUT` and the LED, buzzer or motor pad driver, in the same `i_CLK` domain as the divider.

## Interface
- `WIDTH`, 16, width of the period, duty and count registers.
- `i_CLK` input 1: single system clock, the same clock as the divider.
- `i_RESET_N` input 1: reset, asynchronous assertion, active-low.
- `i_ENABLE` input 1: global run enable. Low freezes counting.
- `i_TICK` input 1: one-cycle strobe, connected to the divider's `o_ENABLE_OUT`.
- `i_LOAD` input 1: one-cycle request to capture `i_PERIOD` and `i_DUTY`.
- `i_PERIOD` input WIDTH: ticks per PWM period. 0 means stop.
- `i_DUTY` input WIDTH: number of high ticks per period.
- `o_PWM` output 1: registered PWM waveform.
- `o_PERIOD_DONE` output 1: one-cycle pulse on the cycle the count wraps.
- `o_LOAD_PENDING` output 1: a captured configuration is waiting to commit.
- `o_COUNT` output WIDTH: current tick position within the period.

## Operation
- Registers:
  - pending period and duty, plus a pending flag;
  - active period and duty;
  - count;
  - state, `IDLE` or `RUN`.
- Reset values: every output is 0, every register is 0, state is `IDLE`.
- Advance condition: `adv = i_ENABLE & i_TICK & (state == RUN)`.
- Wrap condition: `wrap = adv & (count == active_period - 1)`.
- On `adv`:
  - if `wrap`, count goes to 0 and `o_PERIOD_DONE` is 1 for the next cycle;
  - otherwise count increments by 1.
- Capture on `i_LOAD`:
  - `i_PERIOD` and `i_DUTY` go into the pending registers and the pending flag is set;
  - a second load before commit overwrites the pending values (last load wins).
- Commit rules:
  - `IDLE`: a pending configuration commits on the cycle after it is captured, whether or not `i_ENABLE` is high. Count is set to 0. State goes to `RUN` if the committed period is nonzero, otherwise it stays `IDLE`.
  - `RUN`: a pending configuration commits only on a `wrap` cycle. Active registers take the pending values and count goes to 0. If the committed period is 0, state goes to `IDLE`.
  - `i_LOAD` in the same cycle as a `wrap` commit: the new `i_PERIOD`/`i_DUTY` values commit directly and the pending flag ends up 0.
  - `i_LOAD` in the same cycle as an `IDLE` commit: the commit uses the old pending values and the new values become pending.
- PWM computation: `o_PWM` is registered from next-state values, `(state_next == RUN) & (count_next < duty_next)`. This keeps it cycle-aligned with `o_COUNT`.
- Duty edge values:
  - duty 0 gives constant low;
  - duty ≥ period gives constant high (100%), with no glitch at wrap.
- `i_ENABLE` low: count and `o_PWM` hold their values; load capture still works.
- Asynchronous reset mid-period returns all outputs to 0 immediately, independent of the clock.
- Width rules:
  - all comparisons are unsigned, at WIDTH bits;
  - `active_period - 1` is evaluated only in `RUN`, where the period is nonzero, so it cannot underflow.

## Timing
- Tick to update: an `i_TICK` sampled high at edge n updates `o_COUNT` and `o_PWM` after edge n, i.e. one cycle of latency.
- Load from `IDLE`: load at edge n gives pending after n and `RUN` with count 0 after n+1. `o_PWM` is 1 after n+1 if duty > 0.
- `o_PERIOD_DONE` is high for exactly one cycle per wrap and is coincident with `o_COUNT == 0`.
- Back-to-back ticks (divide-by-1, `i_TICK` held high) are supported, giving one count step per clock.
- There is no combinational path from any input to any output.

## Structure
- Shared package `clock_divider_pkg` holds:
  - the state encodings `ST_IDLE` = 0 and `ST_RUN` = 1;
  - the default `WIDTH`.
- One sub-module is natural: `pwm_config_shadow`.
  - It contains the pending and active registers and the commit and priority logic.
  - It has a `commit` input and outputs the active period and duty.
- The top level contains the counter, the state register and the output registers.

## Test plan
- Reset, then period 4, duty 1, tick every cycle → `o_PWM` pattern 1,0,0,0 repeating. `o_PERIOD_DONE` every 4 cycles, with `o_COUNT == 0`.
- Ticks every 3rd cycle, period 5, duty 2 → `o_PWM` high for 6 clocks and low for 9. The count advances only on tick cycles.
- In `RUN` with period 4, duty 2: load period 8, duty 6 at count 1 → `o_LOAD_PENDING` = 1 until the wrap. The new waveform starts exactly at count 0, with no truncated pulse.
- Duty boundary values:
  - duty 0 → `o_PWM` constant 0;
  - duty 7 with period 4 → `o_PWM` constant 1 across wraps;
  - load period 0 → `IDLE`, `o_PWM` = 0 after the next wrap.
- `i_LOAD` coincident with `wrap` → the new configuration is active at count 0 and `o_LOAD_PENDING` = 0. A second load before a wrap → only the last load is applied.
- Deassert `i_ENABLE` at count 2 → count and `o_PWM` freeze. Assert `i_RESET_N` = 0 mid-period → all outputs 0 asynchronously, and state is `IDLE` after release.
